// File: rtl/scariv_vlsu_replay_issue_ctrl.sv
// scariv_vlsu_replay_issue_ctrl: replay/issue arbitration into EX0-EX2 with hazard push and replay-queue credit tracking
module scariv_vlsu_replay_issue_ctrl #(
  parameter int RQ_SIZE   = 8,
  parameter int CMT_ID_W  = 6,
  parameter int GRP_ID_W  = 4,
  parameter int PAYLOAD_W = 64,
  parameter int HAZ_TYP_W = 3,
  parameter int HAZ_IDX_W = 8,
  localparam int CW       = $clog2(RQ_SIZE + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_iss_valid,
  output logic                 o_iss_ready,
  input  logic [CMT_ID_W-1:0]  i_iss_cmt_id,
  input  logic [GRP_ID_W-1:0]  i_iss_grp_id,
  input  logic [PAYLOAD_W-1:0] i_iss_payload,
  input  logic                 i_rpl_valid,
  output logic                 o_rpl_ready,
  input  logic [CMT_ID_W-1:0]  i_rpl_cmt_id,
  input  logic [GRP_ID_W-1:0]  i_rpl_grp_id,
  input  logic [PAYLOAD_W-1:0] i_rpl_payload,
  input  logic                 i_rq_pop,
  input  logic                 i_flush,
  input  logic                 i_ex2_haz_valid,
  input  logic [HAZ_TYP_W-1:0] i_ex2_haz_typ,
  input  logic [HAZ_IDX_W-1:0] i_ex2_haz_index,
  output logic                 o_ex0_valid,
  output logic [CMT_ID_W-1:0]  o_ex0_cmt_id,
  output logic [GRP_ID_W-1:0]  o_ex0_grp_id,
  output logic [PAYLOAD_W-1:0] o_ex0_payload,
  output logic                 o_ex2_valid,
  output logic [CMT_ID_W-1:0]  o_ex2_cmt_id,
  output logic [GRP_ID_W-1:0]  o_ex2_grp_id,
  output logic                 o_done_valid,
  output logic [CMT_ID_W-1:0]  o_done_cmt_id,
  output logic [GRP_ID_W-1:0]  o_done_grp_id,
  output logic                 o_haz_valid,
  output logic [CMT_ID_W-1:0]  o_haz_cmt_id,
  output logic [GRP_ID_W-1:0]  o_haz_grp_id,
  output logic [PAYLOAD_W-1:0] o_haz_payload,
  output logic [HAZ_TYP_W-1:0] o_haz_typ,
  output logic [HAZ_IDX_W-1:0] o_haz_index,
  input  logic                 i_haz_full,
  output logic [CW-1:0]        o_credits
);
  typedef struct packed {
    logic                 v;
    logic [CMT_ID_W-1:0]  cmt;
    logic [GRP_ID_W-1:0]  grp;
    logic [PAYLOAD_W-1:0] pl;
  } stage_t;
  stage_t [2:0] st_q, st_d;
  logic [CW-1:0] credits_q, credits_d;
  logic [1:0] inflight;
  logic acc_rpl, acc_iss;
  // Issue only while every in-flight op could still find a free replay slot.
  always_comb begin
    inflight    = {1'b0, st_q[0].v} + {1'b0, st_q[1].v} + {1'b0, st_q[2].v};
    o_rpl_ready = !i_flush;
    o_iss_ready = !i_flush && !i_rpl_valid && (credits_q > CW'(inflight));
    acc_rpl     = i_rpl_valid && !i_flush;
    acc_iss     = i_iss_valid && o_iss_ready;
    st_d[0]     = acc_rpl ? {1'b1, i_rpl_cmt_id, i_rpl_grp_id, i_rpl_payload} :
                  acc_iss ? {1'b1, i_iss_cmt_id, i_iss_grp_id, i_iss_payload} : '0;
    st_d[1]     = st_q[0];
    st_d[1].v   = st_q[0].v && !i_flush;
    st_d[2]     = st_q[1];
    st_d[2].v   = st_q[1].v && !i_flush;
    o_haz_valid  = st_q[2].v && !i_flush && i_ex2_haz_valid;
    o_done_valid = st_q[2].v && !i_flush && !i_ex2_haz_valid;
    credits_d    = credits_q + CW'(i_rq_pop) - CW'(o_haz_valid);
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      st_q      <= '0;
      credits_q <= CW'(RQ_SIZE);
    end else begin
      st_q      <= st_d;
      credits_q <= credits_d;
      assert (credits_q <= CW'(RQ_SIZE));
      assert (!(credits_q == '0 && o_haz_valid && !i_rq_pop));
      assert (!(credits_q == CW'(RQ_SIZE) && i_rq_pop && !o_haz_valid));
      assert (!(o_haz_valid && i_haz_full));
    end
  end
  assign o_ex0_valid   = st_q[0].v;
  assign o_ex0_cmt_id  = st_q[0].cmt;
  assign o_ex0_grp_id  = st_q[0].grp;
  assign o_ex0_payload = st_q[0].pl;
  assign o_ex2_valid   = st_q[2].v;
  assign o_ex2_cmt_id  = st_q[2].cmt;
  assign o_ex2_grp_id  = st_q[2].grp;
  assign o_done_cmt_id = st_q[2].cmt;
  assign o_done_grp_id = st_q[2].grp;
  assign o_haz_cmt_id  = st_q[2].cmt;
  assign o_haz_grp_id  = st_q[2].grp;
  assign o_haz_payload = st_q[2].pl;
  assign o_haz_typ     = o_haz_valid ? i_ex2_haz_typ : '0;
  assign o_haz_index   = o_haz_valid ? i_ex2_haz_index : '0;
  assign o_credits     = credits_q;
endmodule
